hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core. It generates the forwarding selects for the EX-stage ALU operands. It detects load-use hazards and inserts a bubble for them. It flushes the wrong-path instructions after a taken branch or jump. It also sequences multi-cycle M-extension operations (div/rem) by holding the front of the pipe for a fixed latency. A saturating stall-cycle counter is provided for performance debug.

## Interface
- MDIV_LAT, 32, total EX-stage occupancy in cycles of a multi-cycle op; legal range 2..64
- CNT_W, 32, width of the stall-cycle counter
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- rs1_d, rs2_d  in  5 each  source registers of the instruction in ID
- rs1_e, rs2_e, rd_e  in  5 each  sources and destination of the instruction in EX
- rd_m, rd_w  in  5 each  destinations in MEM / WB
- reg_write_m, reg_write_w  in  1 each  MEM / WB instruction writes the register file
- load_e  in  1  instruction in EX is a load
- pc_src_e  in  1  taken branch or jump resolved in EX
- mdiv_e  in  1  instruction in EX is a multi-cycle op
- forward_a_e, forward_b_e  out  2 each  operand select: 00 register file, 10 ALU result from MEM, 01 result from WB
- stall_f, stall_d, stall_e  out  1 each  hold the IF / ID / EX pipeline registers
- flush_d, flush_e, flush_m  out  1 each  bubble the ID / EX / MEM pipeline registers
- mdiv_busy  out  1  multi-cycle op in progress
- mdiv_done  out  1  one-cycle pulse in the final cycle of a multi-cycle op
- stall_cnt  out  CNT_W  saturating count of cycles with stall_f high

## Operation
- Forwarding is combinational, evaluated independently for operand A (rs1_e) and operand B (rs2_e).
  - Select 10 if the source is nonzero, equals rd_m, and reg_write_m is set.
  - Otherwise select 01 if the source is nonzero, equals rd_w, and reg_write_w is set.
  - Otherwise select 00.
  - MEM has priority over WB. x0 is never forwarded.
- Load-use detection: lw_stall = load_e and rd_e != 0 and (rd_e == rs1_d or rd_e == rs2_d).
- The FSM has two states, RUN and MDIV, and a down-counter mcnt of width clog2(MDIV_LAT).
- RUN state:
  - stall_f = stall_d = lw_stall.
  - flush_e = lw_stall or pc_src_e.
  - flush_d = pc_src_e.
  - stall_e = flush_m = 0.
  - If mdiv_e = 1 and pc_src_e = 0: go to MDIV with mcnt = MDIV_LAT-2, and assert stall_f, stall_d, stall_e and flush_m in that same cycle.
  - mdiv_e and lw_stall cannot both be true, because load_e and mdiv_e are exclusive. If both inputs are high, mdiv_e wins.
- MDIV state:
  - stall_f = stall_d = stall_e = flush_m = 1.
  - flush_d = flush_e = 0. pc_src_e is ignored.
  - Forwarding continues to be computed.
  - mcnt decrements each cycle.
  - When mcnt == 0: assert mdiv_done, deassert stall_e and flush_m, and return to RUN on the next edge. The op's result advances to MEM on that edge.
- mdiv_busy = 1 in every cycle in which the EX op is held: the entry cycle in RUN plus all cycles in MDIV except the final one.
- stall_cnt increments on every edge where stall_f = 1 and holds at all-ones.

## Timing
- Forwarding selects, stalls and flushes are combinational from the inputs and the current state, with no added latency. The only registered state is the FSM, mcnt and stall_cnt.
- A multi-cycle op occupies EX for exactly MDIV_LAT cycles. stall_e is high for the first MDIV_LAT-1 of them. mdiv_done is high only in cycle MDIV_LAT.
- A load-use hazard costs exactly one bubble. A taken branch costs two flushed instructions.
- Reset values:
  - FSM = RUN, mcnt = 0, stall_cnt = 0.
  - All stall, flush and mdiv outputs are 0 while rst is high.
  - Forward selects still track their inputs during reset.
- Reset asserted in the middle of MDIV returns to RUN immediately (asynchronously). The held op is abandoned, and no mdiv_done is emitted.
- Back-to-back multi-cycle ops: mdiv_e seen high in RUN in the cycle after the return starts a new sequence with no gap.

## Test plan
- Forward priority: rs1_e=5, rd_m=5 with reg_write_m=1, rd_w=5 with reg_write_w=1 -> forward_a_e=10. Clear reg_write_m -> 01. Set rs1_e=0 with all matches present -> 00.
- Load-use: load_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for one cycle; stall_cnt increases by 1. With rd_e=0 -> no stall.
- Branch during load-use: pc_src_e=1 together with lw_stall -> flush_d=1, flush_e=1, stall_f=1.
- Multi-cycle op with MDIV_LAT=4: pulse mdiv_e=1 -> stall_e high for 3 cycles, mdiv_done high in the 4th cycle, FSM back in RUN in the 5th, stall_cnt=4.
- Reset mid-op: assert rst in the 2nd MDIV cycle -> all stalls 0 immediately, no mdiv_done, stall_cnt=0. The next mdiv_e restarts the full 4-cycle sequence.
- Saturation: with CNT_W=4, hold lw_stall for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use stall, branch flush and
// multi-cycle (div/rem) sequencing for the five-stage pipeline.
module hazard_ctrl #(
    parameter int MDIV_LAT = 32,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [4:0]       rd_m,
    input  logic [4:0]       rd_w,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             load_e,
    input  logic             pc_src_e,
    input  logic             mdiv_e,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             mdiv_busy,
    output logic             mdiv_done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MW = $clog2(MDIV_LAT);

    typedef enum logic {RUN, MDIV} state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [MW-1:0]    r_mcnt;
    logic [MW-1:0]    w_mcnt_nx;
    logic [CNT_W-1:0] r_cnt;
    logic             w_lw_stall;
    logic             w_mdiv_start;
    logic             w_mzero;

    // MEM result wins over WB; x0 is hardwired and never forwarded
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rdm,
        input logic       wm,
        input logic [4:0] rdw,
        input logic       ww
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0 && rs == rdm && wm)
            sel = 2'b10;
        else if (rs != 5'd0 && rs == rdw && ww)
            sel = 2'b01;
        return sel;
    endfunction

    assign forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    assign forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

    assign w_lw_stall = load_e && (rd_e != 5'd0) &&
                        (rd_e == rs1_d || rd_e == rs2_d);

    // a branch taken in the same cycle squashes the op instead of starting it
    assign w_mdiv_start = mdiv_e && !pc_src_e;
    assign w_mzero      = (r_mcnt == '0);
    assign stall_cnt    = r_cnt;

    // state and latency counter register; reset abandons any held op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_mcnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_mcnt  <= w_mcnt_nx;
        end
    end

    // next state: RUN enters MDIV on a live op, MDIV counts down to zero
    always_comb begin
        w_state_nx = r_state;
        w_mcnt_nx  = r_mcnt;
        unique case (r_state)
            RUN: begin
                if (w_mdiv_start) begin
                    w_state_nx = MDIV;
                    w_mcnt_nx  = MW'(MDIV_LAT - 2);
                end
            end
            MDIV: begin
                if (w_mzero)
                    w_state_nx = RUN;
                else
                    w_mcnt_nx = r_mcnt - MW'(1);
            end
            default: w_state_nx = RUN;
        endcase
    end

    // stall/flush outputs; all forced low while reset is asserted
    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_m   = 1'b0;
        mdiv_busy = 1'b0;
        mdiv_done = 1'b0;
        if (!rst) begin
            unique case (r_state)
                RUN: begin
                    if (w_mdiv_start) begin
                        stall_f   = 1'b1;
                        stall_d   = 1'b1;
                        stall_e   = 1'b1;
                        flush_m   = 1'b1;
                        mdiv_busy = 1'b1;
                    end else begin
                        stall_f = w_lw_stall;
                        stall_d = w_lw_stall;
                        flush_e = w_lw_stall || pc_src_e;
                        flush_d = pc_src_e;
                    end
                end
                MDIV: begin
                    stall_f   = 1'b1;
                    stall_d   = 1'b1;
                    stall_e   = !w_mzero;
                    flush_m   = !w_mzero;
                    mdiv_busy = !w_mzero;
                    mdiv_done = w_mzero;
                end
                default: ;
            endcase
        end
    end

    // saturating count of front-end stall cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (stall_f && r_cnt != '1)
            r_cnt <= r_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table for combinational hazard logic
// plus hand sequences for multi-cycle ops, reset and counter saturation.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       reg_write_m, reg_write_w, load_e, pc_src_e, mdiv_e;
    logic [1:0] forward_a_e, forward_b_e;
    logic       stall_f, stall_d, stall_e;
    logic       flush_d, flush_e, flush_m;
    logic       mdiv_busy, mdiv_done;
    logic [3:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.MDIV_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .rd_m(rd_m), .rd_w(rd_w),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .load_e(load_e), .pc_src_e(pc_src_e), .mdiv_e(mdiv_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .mdiv_busy(mdiv_busy), .mdiv_done(mdiv_done),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic       rwm, rww, ld, pc;
        logic [1:0] fa, fb;
        logic       sf, sd, se, fd, fe, fm;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0;
        rd_m = 0; rd_w = 0; reg_write_m = 0; reg_write_w = 0;
        load_e = 0; pc_src_e = 0; mdiv_e = 0;
    endtask

    task automatic set_lw();
        load_e = 1; rd_e = 5'd7; rs2_d = 5'd7;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1;
        #2 rst = 0;
    endtask

    // Sequence of n cycles starting now; with hold, mdiv_e stays high so
    // a new op starts right after each completes (period 4).
    task automatic mdiv_run(input int n, input logic hold, input string tag);
        logic live, e_se, e_done;
        for (int c = 0; c < n; c++) begin
            live   = hold || (c < 4);
            e_se   = live && (c % 4 != 3);
            e_done = live && (c % 4 == 3);
            if (c == 1) begin
                pc_src_e = 1; rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1;
            end
            if (c == 2) begin
                pc_src_e = 0; rs1_e = 0; rd_m = 0; reg_write_m = 0;
            end
            #1;
            chk($sformatf("%s.c%0d.stall_e", tag, c), 32'(stall_e), 32'(e_se));
            chk($sformatf("%s.c%0d.flush_m", tag, c), 32'(flush_m), 32'(e_se));
            chk($sformatf("%s.c%0d.busy", tag, c), 32'(mdiv_busy), 32'(e_se));
            chk($sformatf("%s.c%0d.done", tag, c), 32'(mdiv_done), 32'(e_done));
            chk($sformatf("%s.c%0d.stall_f", tag, c), 32'(stall_f), 32'(live));
            chk($sformatf("%s.c%0d.stall_d", tag, c), 32'(stall_d), 32'(live));
            if (c == 1) begin
                chk($sformatf("%s.flush_d_ign", tag), 32'(flush_d), 32'd0);
                chk($sformatf("%s.flush_e_ign", tag), 32'(flush_e), 32'd0);
                chk($sformatf("%s.fwd_in_mdiv", tag), 32'(forward_a_e), 32'd2);
            end
            @(posedge clk);
            #1;
            if (!hold) mdiv_e = 0;
        end
    endtask

    initial begin
        //          rs1d rs2d rs1e rs2e rde  rdm  rdw  rwm rww ld pc  fa fb  sf sd se fd fe fm
        tbl[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0,
                    2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0,
                    2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0,
                    2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0,
                    2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0,
                    2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                    2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                    2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                    2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                    2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1,
                    2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1,
                    2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{5'd6, 5'd8, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                    2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // reset state: hazard inputs present but outputs held low
        idle();
        rst = 1;
        set_lw();
        pc_src_e = 1;
        rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1;
        #2;
        chk("rst.stall_f", 32'(stall_f), 32'd0);
        chk("rst.flush_d", 32'(flush_d), 32'd0);
        chk("rst.flush_e", 32'(flush_e), 32'd0);
        chk("rst.cnt", 32'(stall_cnt), 32'd0);
        chk("rst.fwd_a", 32'(forward_a_e), 32'd2);
        @(negedge clk);
        idle();
        rst = 0;

        // combinational vector table in RUN
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rs1_d = tbl[i].rs1_d; rs2_d = tbl[i].rs2_d;
            rs1_e = tbl[i].rs1_e; rs2_e = tbl[i].rs2_e;
            rd_e = tbl[i].rd_e; rd_m = tbl[i].rd_m; rd_w = tbl[i].rd_w;
            reg_write_m = tbl[i].rwm; reg_write_w = tbl[i].rww;
            load_e = tbl[i].ld; pc_src_e = tbl[i].pc; mdiv_e = 0;
            #2;
            chk($sformatf("vec%0d.fa", i), 32'(forward_a_e), 32'(tbl[i].fa));
            chk($sformatf("vec%0d.fb", i), 32'(forward_b_e), 32'(tbl[i].fb));
            chk($sformatf("vec%0d.sf", i), 32'(stall_f), 32'(tbl[i].sf));
            chk($sformatf("vec%0d.sd", i), 32'(stall_d), 32'(tbl[i].sd));
            chk($sformatf("vec%0d.se", i), 32'(stall_e), 32'(tbl[i].se));
            chk($sformatf("vec%0d.fd", i), 32'(flush_d), 32'(tbl[i].fd));
            chk($sformatf("vec%0d.fe", i), 32'(flush_e), 32'(tbl[i].fe));
            chk($sformatf("vec%0d.fm", i), 32'(flush_m), 32'(tbl[i].fm));
        end

        // single load-use bubble bumps the counter once
        do_reset();
        set_lw();
        #1;
        chk("lu.cnt0", 32'(stall_cnt), 32'd0);
        chk("lu.stall_f", 32'(stall_f), 32'd1);
        @(posedge clk);
        #1 idle();
        #1;
        chk("lu.cnt1", 32'(stall_cnt), 32'd1);
        chk("lu.stall_f_off", 32'(stall_f), 32'd0);

        // branch in same cycle as a multi-cycle op: op does not start
        do_reset();
        mdiv_e = 1; pc_src_e = 1;
        #1;
        chk("brmd.stall_e", 32'(stall_e), 32'd0);
        chk("brmd.flush_d", 32'(flush_d), 32'd1);
        @(posedge clk);
        #1 idle();
        #1;
        chk("brmd.stay_run", 32'(mdiv_done | mdiv_busy), 32'd0);

        // single multi-cycle op, then RUN
        do_reset();
        mdiv_e = 1;
        mdiv_run(5, 1'b0, "md");
        chk("md.cnt", 32'(stall_cnt), 32'd4);

        // back-to-back ops with no gap
        do_reset();
        mdiv_e = 1;
        mdiv_run(8, 1'b1, "b2b");
        mdiv_e = 0;
        #1;
        chk("b2b.idle_sf", 32'(stall_f), 32'd0);

        // reset in second MDIV cycle abandons the op
        do_reset();
        mdiv_e = 1;
        @(posedge clk);
        #1 mdiv_e = 0;
        #1;
        chk("rmid.pre_se", 32'(stall_e), 32'd1);
        chk("rmid.pre_cnt", 32'(stall_cnt), 32'd1);
        rst = 1;
        rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1;
        #1;
        chk("rmid.stall_f", 32'(stall_f), 32'd0);
        chk("rmid.stall_e", 32'(stall_e), 32'd0);
        chk("rmid.busy", 32'(mdiv_busy), 32'd0);
        chk("rmid.done", 32'(mdiv_done), 32'd0);
        chk("rmid.cnt", 32'(stall_cnt), 32'd0);
        chk("rmid.fwd", 32'(forward_a_e), 32'd2);
        repeat (3) @(posedge clk);
        #1;
        chk("rmid.done_hold", 32'(mdiv_done), 32'd0);
        rst = 0;
        idle();
        #1;
        chk("rmid.run_idle", 32'(stall_f), 32'd0);
        @(posedge clk);
        #1 mdiv_e = 1;
        mdiv_run(5, 1'b0, "rmid.re");
        chk("rmid.re.cnt", 32'(stall_cnt), 32'd4);

        // counter saturates at all-ones
        do_reset();
        set_lw();
        repeat (20) @(posedge clk);
        #1;
        chk("sat.cnt", 32'(stall_cnt), 32'd15);
        chk("sat.stall_f", 32'(stall_f), 32'd1);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
